imem_loader: RTL and testbench

Program loader that writes RV32I instruction memory from a byte stream. It receives a little-endian word count and then the instruction bytes over a valid/ready byte interface, and assembles 32-bit words. Each word goes out as a single-cycle write on the instruction-memory write port. It holds the core in reset from power-up until a load completes successfully.

---
 rtl/imem_loader_if.sv | 17 +
 rtl/imem_loader.sv | 116 +++++++++++
 tb/tb_imem_loader.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write port of the program loader.
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams a word count plus little-endian RV32I words into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
    parameter int MEM_WORDS = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_rst,
    output logic         busy,
    output logic         done,
    output logic         err
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] HDR_LO = 3'd1;
    localparam logic [2:0] HDR_HI = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] CHK    = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;
    localparam logic [2:0] ERR    = 3'd7;

    logic [2:0]  state;
    logic [15:0] cnt;
    logic [15:0] hdr;
    logic [AW:0] word_idx;
    logic [1:0]  byte_idx;
    logic [31:0] word;
    logic [31:0] word_nxt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        xfer;
    logic        last;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign bus.byte_ready = state == HDR_LO || state == HDR_HI || state == DATA || state == CHK;
    assign bus.mem_we     = state == WRITE;
    assign bus.mem_addr   = addr;
    assign bus.mem_wdata  = wdata;
    assign busy           = bus.byte_ready || state == WRITE;
    assign done           = state == DONE;
    assign err            = state == ERR;
    assign cpu_rst        = state != DONE;

    assign xfer = bus.byte_valid && bus.byte_ready;
    assign hdr  = {bus.byte_data, cnt[7:0]};
    assign last = 16'(word_idx) + 16'd1 == cnt;

    always_comb begin
        word_nxt = word;
        word_nxt[8*byte_idx +: 8] = bus.byte_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            word     <= '0;
            addr     <= '0;
            wdata    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERR: if (start) begin
                    state <= HDR_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum  <= '0;
`endif
                end
                HDR_LO: if (xfer) begin
                    cnt[7:0] <= bus.byte_data;
                    state    <= HDR_HI;
                end
                HDR_HI: if (xfer) begin
                    cnt[15:8] <= bus.byte_data;
                    word_idx  <= '0;
                    byte_idx  <= '0;
                    state     <= (hdr == 16'd0 || {16'd0, hdr} > 32'(MEM_WORDS)) ? ERR : DATA;
                end
                DATA: if (xfer) begin
                    word     <= word_nxt;
                    byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum     <= csum ^ bus.byte_data;
`endif
                    // address and data are captured with the last byte so they are stable during WRITE
                    if (byte_idx == 2'd3) begin
                        addr  <= 32'({word_idx, 2'b00});
                        wdata <= word_nxt;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state    <= last ? CHK : DATA;
`else
                    state    <= last ? DONE : DATA;
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: if (xfer) state <= (bus.byte_data == csum) ? DONE : ERR;
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed streams against imem_loader with hand-computed writes and status.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic cpu_rst, busy, done, err;
    int checks = 0;
    int errors = 0;
    logic [7:0]  stream[$];
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    imem_loader_if bus ();

    imem_loader #(.MEM_WORDS(256)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.mem_we) begin
        wa.push_back(bus.mem_addr);
        wd.push_back(bus.mem_wdata);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, {26'd0, cpu_rst, bus.byte_ready, bus.mem_we, busy, done, err}, 32'b100000);
        check({tag, "_addr"}, bus.mem_addr, 32'h0);
        check({tag, "_wdata"}, bus.mem_wdata, 32'h0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || err) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("end_timeout", 32'd0, 32'd1);
    endtask

    task automatic load(input int gap);
        wa.delete();
        wd.delete();
        pulse_start();
        foreach (stream[i]) send_byte(stream[i], gap);
        wait_end();
    endtask

    task automatic check_two_words(input string tag);
        check({tag, "_nw"}, wa.size(), 2);
        if (wa.size() == 2) begin
            check({tag, "_a0"}, wa[0], 32'h0);
            check({tag, "_d0"}, wd[0], 32'h00100513);
            check({tag, "_a1"}, wa[1], 32'h4);
            check({tag, "_d1"}, wd[1], 32'h00200593);
        end
        check({tag, "_st"}, {28'd0, done, err, busy, cpu_rst}, 32'b1000);
    endtask

    task automatic base_stream();
        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(8'hB0);
`endif
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset("idle");

        base_stream();
        load(0);
        check_two_words("basic");

        stream = '{8'h00, 8'h00};
        load(0);
        check("zero_nw", wa.size(), 0);
        check("zero_st", {27'd0, err, done, cpu_rst, bus.byte_ready, busy}, 32'b10100);

        stream = '{8'h01, 8'h01};
        load(0);
        check("big_nw", wa.size(), 0);
        check("big_st", {27'd0, err, done, cpu_rst, bus.byte_ready, busy}, 32'b10100);

        base_stream();
        load(3);
        check_two_words("stall");

        wa.delete();
        wd.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("midrst");
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.byte_data = 8'(i + 16);
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        check("midrst_nw", wa.size(), 0);
        check("midrst_ctl", {30'd0, cpu_rst, busy}, 32'b10);
        base_stream();
        load(0);
        check_two_words("reload");

        wa.delete();
        wd.delete();
        pulse_start();
        foreach (stream[i]) begin
            start = (i == 4);
            send_byte(stream[i], 0);
        end
        start = 1'b0;
        wait_end();
        check_two_words("busystart");

        pulse_start();
        check("restart_st", {29'd0, busy, done, cpu_rst}, 32'b101);
        stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(8'h22);
`endif
        wa.delete();
        wd.delete();
        foreach (stream[i]) send_byte(stream[i], 0);
        wait_end();
        check("second_nw", wa.size(), 1);
        if (wa.size() == 1) begin
            check("second_a", wa[0], 32'h0);
            check("second_d", wd[0], 32'hDEADBEEF);
        end
        check("second_st", {30'd0, done, cpu_rst}, 32'b10);

`ifdef IMEM_LOADER_CHECKSUM_EN
        base_stream();
        stream[stream.size() - 1] = 8'hB1;
        load(0);
        check("badsum_nw", wa.size(), 2);
        check("badsum_st", {29'd0, err, done, cpu_rst}, 32'b101);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
